// File: rtl/test_bsg_data_gen_sched_pkg.sv
// Shared types for the data-generator scheduler: sequencing state encoding.
package test_bsg_data_gen_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/test_bsg_data_gen_sched_join.sv
// Fork/join tracker: remembers which enabled channels have taken the current
// word and flags the cycle in which the last outstanding channel accepts it.
module test_bsg_data_gen_sched_join #(
  parameter int num_channels_p = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      active,
  input  logic [num_channels_p-1:0] mask,
  input  logic [num_channels_p-1:0] ready,
  output logic [num_channels_p-1:0] v,
  output logic                      join_done
);

  logic [num_channels_p-1:0] sent_r;
  logic [num_channels_p-1:0] sent_nxt;

  // Ready on disabled or already-served channels is masked off by v.
  assign v         = {num_channels_p{active}} & mask & ~sent_r;
  assign sent_nxt  = sent_r | (v & ready);
  assign join_done = active & (sent_nxt == mask);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sent_r <= '0;
    end else if (clear || join_done) begin
      sent_r <= '0;
    end else begin
      sent_r <= sent_nxt;
    end
  end

endmodule

// File: rtl/test_bsg_data_gen_sched.sv
// Bursts generator words onto parallel valid/ready channels with fork/join
// delivery, a programmable inter-word gap and a done pulse at burst end.
//
//  state | meaning
//  IDLE  | waiting for start_i; config latched on start
//  SEND  | presenting current word to channels not yet served
//  GAP   | idle cycles between words after a join
//  DONE  | one-cycle completion pulse, then back to IDLE
module test_bsg_data_gen_sched
  import test_bsg_data_gen_sched_pkg::*;
#(
  parameter int channel_width_p = 16,
  parameter int num_channels_p  = 4,
  parameter int count_width_p   = 16,
  parameter int gap_width_p     = 4
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      start_i,
  input  logic [count_width_p-1:0]                  num_words_i,
  input  logic [gap_width_p-1:0]                    gap_i,
  input  logic [num_channels_p-1:0]                 chan_mask_i,
  input  logic [channel_width_p*num_channels_p-1:0] gen_data_i,
  output logic                                      gen_yumi_o,
  output logic [num_channels_p-1:0]                 v_o,
  output logic [channel_width_p*num_channels_p-1:0] data_o,
  input  logic [num_channels_p-1:0]                 ready_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic [count_width_p-1:0]                  sent_count_o
);

  state_e                    state_r, state_nxt;
  logic [count_width_p-1:0]  num_words_r;
  logic [count_width_p-1:0]  sent_count_r;
  logic [count_width_p-1:0]  count_inc;
  logic [gap_width_p-1:0]    gap_r;
  logic [gap_width_p-1:0]    gap_cnt_r;
  logic [num_channels_p-1:0] mask_r;
  logic                      start_accept;
  logic                      join_done;

  assign start_accept = (state_r == IDLE) && start_i;
  assign count_inc    = sent_count_r + count_width_p'(1);

  test_bsg_data_gen_sched_join #(
    .num_channels_p(num_channels_p)
  ) join_u (
    .clk       (clk_i),
    .reset_n   (reset_n_i),
    .clear     (start_accept),
    .active    (state_r == SEND),
    .mask      (mask_r),
    .ready     (ready_i),
    .v         (v_o),
    .join_done (join_done)
  );

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (num_words_i == '0 || chan_mask_i == '0) state_nxt = DONE;
          else                                        state_nxt = SEND;
        end
      end
      SEND: begin
        if (join_done) begin
          if (count_inc == num_words_r) state_nxt = DONE;
          else if (gap_r != '0)         state_nxt = GAP;
          else                          state_nxt = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_r == gap_width_p'(1)) state_nxt = SEND;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      num_words_r  <= '0;
      gap_r        <= '0;
      mask_r       <= '0;
      gap_cnt_r    <= '0;
      sent_count_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (start_accept) begin
        num_words_r  <= num_words_i;
        gap_r        <= gap_i;
        mask_r       <= chan_mask_i;
        sent_count_r <= '0;
      end
      // Gap timer loads on every join; it only matters when GAP follows.
      if (join_done) begin
        sent_count_r <= count_inc;
        gap_cnt_r    <= gap_r;
      end else if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r - gap_width_p'(1);
      end
    end
  end

  assign gen_yumi_o   = join_done;
  assign data_o       = gen_data_i;
  assign busy_o       = (state_r != IDLE);
  assign done_o       = (state_r == DONE);
  assign sent_count_o = sent_count_r;

endmodule

// File: tb/tb_test_bsg_data_gen_sched.sv
// Directed bench: stimulus pushes expected words/done records; a negedge
// monitor pops them whenever the DUT issues gen_yumi_o or done_o.
module tb_test_bsg_data_gen_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] num_words;
  logic [3:0]  gap;
  logic [3:0]  chan_mask;
  logic [63:0] gen_data;
  logic        gen_yumi;
  logic [3:0]  v;
  logic [63:0] data;
  logic [3:0]  ready;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  test_bsg_data_gen_sched dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .num_words_i  (num_words),
    .gap_i        (gap),
    .chan_mask_i  (chan_mask),
    .gen_data_i   (gen_data),
    .gen_yumi_o   (gen_yumi),
    .v_o          (v),
    .data_o       (data),
    .ready_i      (ready),
    .busy_o       (busy),
    .done_o       (done),
    .sent_count_o (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [63:0] data;
    logic [15:0] count;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  int     word_idx = 0;
  int     exp_idx = 0;
  bit     mon_en = 0;
  logic [3:0] exp_mask = '0;

  function automatic logic [63:0] gen_word(input int idx);
    logic [15:0] b;
    b = 16'(idx);
    return {16'hD000 | b, 16'hC000 | b, 16'hB000 | b, 16'hA000 | b};
  endfunction

  always @(posedge clk) if (gen_yumi) word_idx <= word_idx + 1;
  always_comb gen_data = gen_word(word_idx);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int num, input int g, input logic [3:0] m);
    exp_t e;
    num_words = 16'(num);
    gap       = 4'(g);
    chan_mask = m;
    start     = 1'b1;
    exp_mask  = m;
    if (num == 0 || m == 4'b0) begin
      e.is_done = 1; e.data = '0; e.count = 16'd0;
      q.push_back(e);
    end else begin
      for (int i = 0; i < num; i++) begin
        e.is_done = 0; e.data = gen_word(exp_idx); e.count = '0;
        q.push_back(e);
        exp_idx++;
      end
      e.is_done = 1; e.data = '0; e.count = 16'(num);
      q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("v_within_mask", {60'd0, v & ~exp_mask}, 64'd0);
      chk("data_passthru", data, gen_data);
      if (gen_yumi) begin
        if (q.size() == 0) chk("sb_unexpected_yumi", 64'd1, 64'd0);
        else begin
          mon_e = q.pop_front();
          chk("sb_kind_word", {63'd0, mon_e.is_done}, 64'd0);
          chk("sb_word_data", data, mon_e.data);
        end
      end
      if (done) begin
        if (q.size() == 0) chk("sb_unexpected_done", 64'd1, 64'd0);
        else begin
          mon_e = q.pop_front();
          chk("sb_kind_done", {63'd0, mon_e.is_done}, 64'd1);
          chk("sb_done_count", {48'd0, sent_count}, {48'd0, mon_e.count});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t3 [6];
    logic [3:0] t6 [8];
    logic [3:0] rv, ev;
    logic [63:0] w;
    t3 = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0};
    t6 = '{4'h3, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 4'h0};

    reset_n = 0; start = 0; ready = '0; num_words = '0; gap = '0; chan_mask = '0;
    tick(); tick();
    chk("rst_v", {60'd0, v}, 64'd0);
    chk("rst_yumi", {63'd0, gen_yumi}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {48'd0, sent_count}, 64'd0);
    reset_n = 1; mon_en = 1;
    tick();

    // 1: back-to-back words, all channels ready
    ready = 4'hF;
    start_burst(3, 0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      chk("t1_v", {60'd0, v}, 64'hF);
      chk("t1_yumi", {63'd0, gen_yumi}, 64'd1);
      tick();
    end
    chk("t1_done", {63'd0, done}, 64'd1);
    tick();
    chk("t1_idle", {63'd0, busy}, 64'd0);
    chk("t1_count_hold", {48'd0, sent_count}, 64'd3);

    // 2: staggered ready, single join at cycle 7
    ready = '0;
    start_burst(1, 0, 4'hF);
    w = gen_word(exp_idx - 1);
    for (int k = 0; k < 8; k++) begin
      rv = '0; ev = '0;
      for (int c = 0; c < 4; c++) begin
        rv[c] = (k >= 2 * c + 1);
        ev[c] = (2 * c + 1 >= k);
      end
      ready = rv;
      #1;
      chk("t2_v", {60'd0, v}, {60'd0, ev});
      chk("t2_yumi", {63'd0, gen_yumi}, {63'd0, k == 7});
      chk("t2_data_stable", data, w);
      tick();
    end
    chk("t2_done", {63'd0, done}, 64'd1);
    ready = '0;
    tick();
    chk("t2_count", {48'd0, sent_count}, 64'd1);

    // 3: partial mask with a 3-cycle gap
    ready = 4'hF;
    start_burst(2, 3, 4'b0101);
    for (int k = 0; k < 6; k++) begin
      chk("t3_v", {60'd0, v}, {60'd0, t3[k]});
      chk("t3_done", {63'd0, done}, {63'd0, k == 5});
      tick();
    end
    chk("t3_count", {48'd0, sent_count}, 64'd2);

    // 4: empty bursts
    start_burst(0, 0, 4'hF);
    chk("t4a_done", {63'd0, done}, 64'd1);
    chk("t4a_v", {60'd0, v}, 64'd0);
    tick();
    chk("t4a_count", {48'd0, sent_count}, 64'd0);
    start_burst(5, 1, 4'h0);
    chk("t4b_done", {63'd0, done}, 64'd1);
    chk("t4b_yumi", {63'd0, gen_yumi}, 64'd0);
    tick();
    chk("t4b_busy", {63'd0, busy}, 64'd0);

    // 5: reset with half the channels served
    ready = 4'b0011;
    start_burst(2, 0, 4'hF);
    chk("t5_v_first", {60'd0, v}, 64'hF);
    tick();
    chk("t5_v_half", {60'd0, v}, 64'hC);
    ready = '0;
    reset_n = 0;
    foreach (q[i]) if (!q[i].is_done) exp_idx--;
    q.delete();
    tick();
    chk("t5_rst_v", {60'd0, v}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_count", {48'd0, sent_count}, 64'd0);
    reset_n = 1;
    tick();
    start_burst(1, 0, 4'hF);
    chk("t5_restart_v", {60'd0, v}, 64'hF);
    ready = 4'hF;
    #1;
    chk("t5_restart_yumi", {63'd0, gen_yumi}, 64'd1);
    tick();
    chk("t5_restart_done", {63'd0, done}, 64'd1);
    tick();

    // 6: start pulses during SEND/GAP are ignored
    start_burst(3, 2, 4'b0011);
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin
        start = 1; num_words = 16'd1; gap = 4'd0; chan_mask = 4'hF;
      end else begin
        start = 0;
      end
      chk("t6_v", {60'd0, v}, {60'd0, t6[k]});
      chk("t6_done", {63'd0, done}, {63'd0, k == 7});
      tick();
    end
    start = 0;
    chk("t6_count", {48'd0, sent_count}, 64'd3);
    chk("t6_idle", {63'd0, busy}, 64'd0);

    tick();
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
